fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the single-issue RV32 core. It owns the program counter, drives the instruction-memory address, and registers the returned word. It splits the word into the opcode/func3/func7/register fields consumed by the decode controller, and generates that controller's `bubble` input on reset, flush and halt. It sits directly upstream of the decode controller.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_pc_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants,
// the canonical NOP, FSM state encoding and the RV32 instruction field layout.
package fetch_stage_pkg;

  localparam int unsigned InstW = 32;

  localparam logic [6:0]       InstSystem = 7'b1110011;
  localparam logic [InstW-1:0] NOPInst    = 32'h0000_0013;

  typedef enum logic {
    FSRun  = 1'b0,
    FSHalt = 1'b1
  } fetch_state_e;

  // R-type view of a 32-bit instruction word; other formats reuse the same slices.
  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv_instr_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register.
// Ports: clk_i/rst_i (async active-high), hold_i keeps the PC, load_i takes
// load_pc_i (priority over hold_i); otherwise the PC advances by 4 (mod 2^XLEN).
// pc_o is the registered PC.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next PC: load beats hold beats increment.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Ports: clk, reset (async active-high); stall/redirect/redirectPC from hazard
// and branch logic; imemAddr/imemData to instruction memory (combinational
// read); instr/pcOut/pc4Out and the decoded fields to decode; bubble marks an
// empty IF/ID slot; halted/misalign report the HALT state and its cause.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirectPC,
  output logic [XLEN-1:0]  imemAddr,
  input  logic [InstW-1:0] imemData,
  output logic [InstW-1:0] instr,
  output logic [XLEN-1:0]  pcOut,
  output logic [XLEN-1:0]  pc4Out,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       func7,
  output logic             bubble,
  output logic             halted,
  output logic             misalign
);

  fetch_state_e     state_q, state_d;
  logic [InstW-1:0] instr_q, instr_d;
  logic [XLEN-1:0]  pcout_q, pcout_d;
  logic             bubble_q, bubble_d;
  logic             misalign_q, misalign_d;
  logic             pc_hold;
  logic             pc_load;
  logic [XLEN-1:0]  pc;
  rv_instr_t        fields;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_i     (reset),
    .hold_i    (pc_hold),
    .load_i    (pc_load),
    .load_pc_i (redirectPC),
    .pc_o      (pc)
  );

  // Next-state and IF/ID update; everything holds unless a RUN rule fires.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pcout_d    = pcout_q;
    bubble_d   = bubble_q;
    misalign_d = misalign_q;
    pc_hold    = 1'b1;
    pc_load    = 1'b0;

    unique case (state_q)
      FSRun: begin
        if (redirect && is_misaligned(redirectPC[1:0])) begin
          state_d    = FSHalt;
          misalign_d = 1'b1;
          instr_d    = NOPInst;
          bubble_d   = 1'b1;
        end else if (redirect) begin
          // Redirect overrides stall; the word fetched this cycle is killed.
          pc_hold  = 1'b0;
          pc_load  = 1'b1;
          instr_d  = NOPInst;
          bubble_d = 1'b1;
        end else if (stall) begin
          pc_hold = 1'b1;
        end else if (!bubble_q && (fields.opcode == InstSystem)) begin
          // ECALL/EBREAK reached decode: stop fetching for good.
          state_d  = FSHalt;
          instr_d  = NOPInst;
          bubble_d = 1'b1;
        end else begin
          pc_hold  = 1'b0;
          instr_d  = imemData;
          pcout_d  = pc;
          bubble_d = 1'b0;
        end
      end
      FSHalt: begin
        pc_hold = 1'b1;
      end
      default: begin
        state_d = FSHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FSRun;
      instr_q    <= NOPInst;
      pcout_q    <= '0;
      bubble_q   <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pcout_q    <= pcout_d;
      bubble_q   <= bubble_d;
      misalign_q <= misalign_d;
    end
  end

  assign fields = rv_instr_t'(instr_q);

  assign imemAddr = pc;
  assign instr    = instr_q;
  assign pcOut    = pcout_q;
  assign pc4Out   = pcout_q + XLEN'(4);
  assign opcode   = fields.opcode;
  assign rd       = fields.rd;
  assign func3    = fields.func3;
  assign rs1      = fields.rs1;
  assign rs2      = fields.rs2;
  assign func7    = fields.func7;
  assign bubble   = bubble_q;
  assign halted   = (state_q == FSHalt);
  assign misalign = misalign_q;

endmodule
